// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the asynchronous instruction memory and
// holds the fetched word in an IF/ID register with a valid/ready handshake.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_AW    = 6,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4,
  output logic [1:0]         state,
  output logic [31:0]        fault_pc
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic redirect_c;
  logic redirect_bad_c;
  logic advance_c;
  logic in_range_c;
  logic is_halt_c;

  // Event decode shared by the next-state and datapath logic
  always_comb begin
    redirect_c     = redirect_valid && (state_q != ST_FAULT);
    redirect_bad_c = redirect_c && (redirect_pc[1:0] != 2'b00);
    advance_c      = (state_q == ST_RUN) && (!id_valid_q || id_ready);
    in_range_c     = (pc_q[31:IMEM_AW+2] == '0) && (pc_q[1:0] == 2'b00);
    is_halt_c      = (imem_data == HALT_INSTR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_c) begin
      state_d = redirect_bad_c ? ST_FAULT : ST_RUN;
    end else if (advance_c) begin
      if (!in_range_c)    state_d = ST_FAULT;
      else if (is_halt_c) state_d = ST_HALT;
    end
  end

  // Datapath: an IF/ID entry drains on id_ready unless refilled or flushed
  always_comb begin
    pc_d          = pc_q;
    id_valid_d    = id_valid_q && !id_ready;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    fault_pc_d    = fault_pc_q;
    if (redirect_c) begin
      id_valid_d = 1'b0;
      if (redirect_bad_c) fault_pc_d = redirect_pc;
      else                pc_d       = redirect_pc;
    end else if (advance_c) begin
      if (!in_range_c) begin
        fault_pc_d = pc_q;
      end else if (!is_halt_c) begin
        id_instr_d    = imem_data;
        id_pc_d       = pc_q;
        id_pc_plus4_d = pc_q + 32'd4;
        id_valid_d    = 1'b1;
        pc_d          = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      fault_pc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign state       = state_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly upstream of the 64-word instruction memory. It owns the program counter and drives the word address into the asynchronous-read instruction memory. It captures the returned instruction into an IF/ID register with a valid/ready handshake towards decode. It also handles branch/jump redirects, decode back-pressure, a halt sentinel, and address faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_AW, 6, instruction memory word-address width (memory depth = 2**IMEM_AW words)
HALT_INSTR, 32'hFFFF_FFFF, sentinel instruction that stops fetch

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
imem_addr  out  IMEM_AW  word address to instruction memory, equal to pc[IMEM_AW+1:2]
imem_data  in  32  instruction from memory, same cycle (combinational read)
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  target byte address
id_valid  out  1  IF/ID register holds an instruction
id_ready  in  1  decode accepts IF/ID contents this cycle
id_instr  out  32  fetched instruction
id_pc  out  32  byte address of id_instr
id_pc_plus4  out  32  id_pc + 4
state  out  2  00 RUN, 01 HALT, 10 FAULT
fault_pc  out  32  PC that caused FAULT

Behaviour:
- Reset (async, reset_n=0), all outputs take their reset values immediately:
  - pc=RESET_PC; state=RUN; id_valid=0.
  - id_instr, id_pc, id_pc_plus4, fault_pc = 0.
  - imem_addr follows pc.
- Definitions: pc is the internal register. advance = (state==RUN) && (!id_valid || id_ready). in_range = pc[31:IMEM_AW+2]==0 && pc[1:0]==0.
- Priority per cycle, evaluated at the rising edge: redirect > fault > halt > advance > hold.
- Redirect (redirect_valid=1), in state RUN or HALT:
  - If redirect_pc[1:0]!=0: state<=FAULT, fault_pc<=redirect_pc, id_valid<=0.
  - Otherwise: pc<=redirect_pc, id_valid<=0 (flush the wrong-path instruction), state<=RUN.
  - Redirect overrides a stall; the flushed instruction is dropped even if id_ready=0.
  - A redirect in FAULT is ignored.
- RUN, advance=1, no redirect:
  - If !in_range: state<=FAULT, fault_pc<=pc, id_valid<=0 if id_ready (held otherwise).
  - Else if imem_data==HALT_INSTR: state<=HALT. The sentinel is not delivered; id_valid<=0 if id_ready, else held. pc is unchanged.
  - Else: id_instr<=imem_data, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
- RUN, advance=0 (id_valid=1, id_ready=0): pc and the IF/ID register hold; imem_addr is stable.
- HALT:
  - No fetch; a pending IF/ID entry drains when id_ready=1.
  - A redirect returns to RUN (the halt was on the wrong path).
- FAULT: terminal until reset; no fetch; id_valid=0 once drained.
- Latency: imem_addr to id_instr is one cycle. Throughput is one instruction per cycle while id_ready=1.
- Arithmetic: pc+4 is a 32-bit add with wrap; wrap beyond the memory range lands in FAULT via in_range.
- Reset asserted mid-stall or mid-redirect: everything returns to reset values at once, with no partial update.

Test Plan:
- Reset release, memory words 0..3 = 0x20080001,0x20090002,0x01095020,0xFFFFFFFF, id_ready=1 -> id_valid=1 with (id_pc,id_instr) = (0,0x20080001), (4,0x20090002), (8,0x01095020) on consecutive cycles; then state=HALT, id_valid=0, pc stays 12.
- id_ready held 0 for 3 cycles after the first fetch -> id_instr stays 0x20080001, id_pc stays 0, imem_addr stays 1; fetch resumes at pc=4 the cycle id_ready=1.
- Redirect to 0x20 while id_valid=1 and id_ready=0 -> next cycle id_valid=0, pc=0x20, imem_addr=8; following cycle id_pc=0x20.
- In HALT, redirect_valid=1 with redirect_pc=0x10 -> state=RUN, next delivered id_pc=0x10.
- Redirect to 0x102 -> state=FAULT, fault_pc=0x102. Separately, pc reaching 0x100 with IMEM_AW=6 -> FAULT, fault_pc=0x100. A later redirect is ignored.
- reset_n pulsed low mid-stream, asynchronously between edges -> id_valid=0 and pc=RESET_PC immediately; state=RUN.
